// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Owns a loadable instruction memory and hands one instruction at a time to
//   the processor core. The PC advances on each rising edge of proc_done; a run
//   ends on the last instruction, on a reported result, or when the watchdog
//   expires while waiting for the core.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   load_en/addr/data     memory write port (accepted in IDLE only)
//   prog_len              instructions to run, sampled on accepted start
//   start                 start request (accepted in IDLE only)
//   proc_done             core completion level (each rising edge = one done)
//   disp_avail/value      core result, sampled with the done edge
//   instr, instr_valid    instruction presented to the core
//   pc                    address of the current instruction
//   busy                  high outside IDLE
//   result, result_valid  captured result of the current/last run
//   finished              one-cycle pulse when a run ends
//   err_timeout           last run was aborted by the watchdog
module instr_sequencer #(
  parameter int unsigned IW      = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          proc_done,
  input  logic          disp_avail,
  input  logic [DW-1:0] disp_value,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic          finished,
  output logic          err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_END
  } state_e;

  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] mem_q [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [DW-1:0] result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          err_q, err_d;
  logic [AW:0]   len_q, len_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          done_q;
  logic          done_edge;

  assign done_edge = proc_done & ~done_q;

  // Memory is deliberately not reset; contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      instr_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      len_q          <= '0;
      wd_q           <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      len_q          <= len_d;
      wd_q           <= wd_d;
      done_q         <= proc_done;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_d          = err_q;
    len_d          = len_q;
    wd_d           = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d           = '0;
          result_valid_d = 1'b0;
          err_d          = 1'b0;
          if (prog_len == '0) begin
            state_d = S_END;
          end else begin
            // Clamping to DEPTH guarantees the PC never wraps.
            len_d   = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        instr_d = mem_q[pc_q];
        wd_d    = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_d = wd_q + 1'b1;
        // A done edge beats a watchdog expiry in the same cycle.
        if (done_edge) begin
          if (disp_avail) begin
            result_d       = disp_value;
            result_valid_d = 1'b1;
            state_d        = S_END;
          end else if ({1'b0, pc_q} == len_q - 1'b1) begin
            state_d = S_END;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_END;
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign instr        = instr_q;
  assign instr_valid  = (state_q == S_ISSUE);
  assign pc           = pc_q;
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign finished     = (state_q == S_END);
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned TO    = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          proc_done = 1'b0;
  logic          disp_avail = 1'b0;
  logic [DW-1:0] disp_value = '0;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          finished;
  logic          err_timeout;

  instr_sequencer #(.IW(IW), .DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start),
    .proc_done(proc_done), .disp_avail(disp_avail), .disp_value(disp_value),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy),
    .result(result), .result_valid(result_valid), .finished(finished),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {int pc; logic [IW-1:0] ins;} iss_t;
  typedef struct {bit chk; bit rv; logic [DW-1:0] val; bit err;} fin_t;

  iss_t          exp_iss[$];
  fin_t          exp_fin[$];
  iss_t          ei;
  fin_t          ef;
  logic [IW-1:0] mem_m [DEPTH];
  int            n_checks = 0;
  int            n_fail = 0;
  int            iss_cnt = 0;
  int            fin_cnt = 0;
  logic          prev_iv = 1'b0;
  logic          prev_fin = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT issues or finishes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid && !prev_iv) begin
        iss_cnt++;
        if (exp_iss.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue actual pc=%0d required none", pc);
        end else begin
          ei = exp_iss.pop_front();
          check("issue_pc", pc, ei.pc);
          check("issue_instr", instr, ei.ins);
        end
      end
      if (finished) begin
        fin_cnt++;
        check("fin_single", prev_fin, 0);
        check("fin_no_iv", instr_valid, 0);
        if (exp_fin.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_finish actual=1 required=0");
        end else begin
          ef = exp_fin.pop_front();
          if (ef.chk) begin
            check("fin_result_valid", result_valid, ef.rv);
            if (ef.rv) check("fin_result", result, ef.val);
            check("fin_err_timeout", err_timeout, ef.err);
          end
        end
      end
    end
    prev_iv  = instr_valid;
    prev_fin = finished;
  end

  task automatic load(input int addr, input logic [IW-1:0] data);
    load_en   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    tick();
    load_en   = 1'b0;
    mem_m[addr] = data;
  endtask

  task automatic wait_iv(output bit ok);
    int c = 0;
    while (!instr_valid && c < 50) begin
      tick();
      c++;
    end
    ok = instr_valid;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_instr_valid actual=timeout required=instr_valid");
    end
  endtask

  // dly < 0 picks a random 1..4 cycle core latency per instruction.
  task automatic run_prog(input int len, input int res_idx, input logic [DW-1:0] rval,
                          input int dly, input int hold, input bit poke, input int abort_at);
    int n, stop, base_i, base_f, d;
    bit rv, ok;
    n    = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    rv   = (res_idx >= 0 && res_idx < n);
    stop = rv ? res_idx + 1 : n;
    for (int i = 0; i < stop; i++) exp_iss.push_back('{i, mem_m[i]});
    exp_fin.push_back('{len != 0, rv, rval, 1'b0});
    base_i = iss_cnt;
    base_f = fin_cnt;
    prog_len = (AW+1)'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (stop == 0) check("empty_fin_pulse", finished, 1);
    for (int k = 0; k < stop; k++) begin
      wait_iv(ok);
      if (!ok) return;
      if (k == abort_at) begin
        check("abort_pc", pc, k);
        rst_n = 1'b0;
        #1;
        check("rst_instr", instr, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_finished", finished, 0);
        check("rst_err_timeout", err_timeout, 0);
        exp_iss.delete();
        exp_fin.delete();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      if (poke && k == 0) begin
        load_en   = 1'b1;
        load_addr = AW'(3);
        load_data = ~mem_m[3];
        start     = 1'b1;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
      end
      d = (dly < 0) ? int'($urandom_range(1, 4)) : dly;
      repeat (d) tick();
      proc_done  = 1'b1;
      disp_avail = (k == res_idx);
      disp_value = (k == res_idx) ? rval : DW'($urandom);
      tick();
      disp_avail = 1'b0;
      if (k == stop - 1) check("fin_after_last_done", finished, 1);
      if (k == 0 && hold > 1) begin
        repeat (hold - 1) tick();
        check("level_pc", pc, 1);
        check("level_iv", instr_valid, 1);
      end
      proc_done = 1'b0;
    end
    tick();
    check("idle_after_end", busy, 0);
    check("n_issued", iss_cnt - base_i, stop);
    check("n_finished", fin_cnt - base_f, 1);
  endtask

  task automatic run_wd(input bit done_at_limit);
    int c;
    bit ok;
    exp_iss.push_back('{0, mem_m[0]});
    if (done_at_limit) begin
      exp_iss.push_back('{1, mem_m[1]});
      exp_fin.push_back('{1'b1, 1'b0, '0, 1'b0});
    end else begin
      exp_fin.push_back('{1'b1, 1'b0, '0, 1'b1});
    end
    prog_len = (AW+1)'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_iv(ok);
    if (!ok) return;
    if (!done_at_limit) begin
      c = 0;
      while (!finished && c < 100) begin
        tick();
        c++;
      end
      check("wd_cycles", c, TO);
      check("wd_err", err_timeout, 1);
      tick();
    end else begin
      repeat (TO - 1) tick();
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      check("wd_race_err", err_timeout, 0);
      check("wd_race_pc", pc, 1);
      check("wd_race_iv", instr_valid, 0);
      wait_iv(ok);
      if (!ok) return;
      repeat (2) tick();
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      check("wd_race_fin", finished, 1);
      check("wd_race_err_end", err_timeout, 0);
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=hang required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [IW-1:0] prog [7];
    prog = '{32'h2401002d, 32'h2402ffec, 32'h2403ffc4, 32'h2404001e,
             32'h00222821, 32'h00643021, 32'h00a62823};
    #2;
    check("reset_pc", pc, 0);
    check("reset_instr", instr, 0);
    check("reset_busy", busy, 0);
    check("reset_iv", instr_valid, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_finished", finished, 0);
    check("reset_err", err_timeout, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full program with result on the 7th done.
    for (int i = 0; i < 7; i++) load(i, prog[i]);
    load(7, 32'hdeadbeef);
    run_prog(7, 6, 16'd5, 3, 0, 1'b0, -1);
    check("full_result", result, 5);
    check("full_result_valid", result_valid, 1);
    check("full_err", err_timeout, 0);
    check("full_pc_hold", pc, 6);

    // Program end without result.
    run_prog(3, -1, '0, -1, 0, 1'b0, -1);
    check("noresult_valid", result_valid, 0);

    // Done held high for 10 cycles advances once.
    run_prog(3, -1, '0, 2, 10, 1'b0, -1);

    // Watchdog expiry and done edge at the limit.
    run_wd(1'b0);
    run_wd(1'b1);

    // Boundaries.
    run_prog(0, -1, '0, -1, 0, 1'b0, -1);
    run_prog(12, -1, '0, -1, 0, 1'b0, -1);
    run_prog(8, -1, '0, -1, 0, 1'b1, -1);
    run_prog(8, -1, '0, -1, 0, 1'b0, -1);

    // Reset while pc = 4, then rerun from preserved memory.
    run_prog(8, -1, '0, -1, 0, 1'b0, 4);
    run_prog(8, -1, '0, -1, 0, 1'b0, -1);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 1) == 1) load(int'($urandom_range(0, DEPTH - 1)), $urandom);
      run_prog(int'($urandom_range(0, 12)), int'($urandom_range(0, 13)) - 1,
               DW'($urandom), -1, 0, 1'($urandom_range(0, 1)), -1);
    end

    check("iss_queue_drained", exp_iss.size(), 0);
    check("fin_queue_drained", exp_fin.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Parametrised instruction sequencer that owns a loadable instruction memory and feeds one instruction at a time to the processor core. It advances its program counter on each completion (`proc_done` rising edge) and stops when the program ends, a result is reported, or the core stalls past a watchdog limit. It sits between the test/boot environment and the processor core, and is the synthesizable successor of the bench-level fetch loop.

## Interface

Parameters:
- `IW`, default 32, instruction width in bits.
- `DEPTH`, default 8, instruction memory depth in words (power of two, ≥2).
- `AW`, default `$clog2(DEPTH)`, address / PC width.
- `DW`, default 16, result value width.
- `TIMEOUT`, default 255, maximum cycles in ISSUE without a done edge (≥1).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  memory write strobe; honoured only in IDLE.
- `load_addr`  in  AW  write address.
- `load_data`  in  IW  write data.
- `prog_len`  in  AW+1  number of instructions to run; sampled on accepted start.
- `start`  in  1  start request; honoured only in IDLE.
- `proc_done`  in  1  core completion level; each rising edge is one completion.
- `disp_avail`  in  1  core has a result; sampled with the done edge.
- `disp_value`  in  DW  core result; sampled with the done edge.
- `instr`  out  IW  instruction presented to the core.
- `instr_valid`  out  1  `instr` is valid (ISSUE state).
- `pc`  out  AW  address of the current instruction.
- `busy`  out  1  high in any state except IDLE.
- `result`  out  DW  captured result.
- `result_valid`  out  1  `result` holds a value from the current/last run.
- `finished`  out  1  one-cycle pulse when a run ends.
- `err_timeout`  out  1  last run was aborted by the watchdog.

## Operation

- FSM states: IDLE, FETCH, ISSUE, END.
- IDLE:
  - `load_en` writes `mem[load_addr] <= load_data`.
  - `start` with `prog_len` = 0 → END (no instruction issued).
  - `start` with `prog_len` > `DEPTH` is clamped to `DEPTH`.
  - Otherwise → FETCH with `pc` = 0, `result_valid` and `err_timeout` cleared.
- FETCH: synchronous memory read, `instr <= mem[pc]` → ISSUE; the watchdog counter is cleared.
- ISSUE: `instr_valid` = 1; the watchdog increments every cycle.
- Done edge detection: `done_edge = proc_done & ~done_q`. `done_q` is a registered copy of `proc_done`, reset to 0. A level held high counts once.
- On `done_edge` in ISSUE, in priority order:
  1. `disp_avail` = 1: `result <= disp_value`, `result_valid <= 1`, go to END.
  2. `pc` = `prog_len`−1: go to END.
  3. Otherwise `pc <= pc+1`, go to FETCH.
- Watchdog: if the counter reaches `TIMEOUT` with no done edge, `err_timeout <= 1` and go to END. A done edge in the same cycle wins; no error is flagged.
- END: `finished` = 1 for exactly one cycle, then IDLE. `result`, `result_valid`, `err_timeout` and `pc` hold until the next accepted start.
- Done edges outside ISSUE are ignored (but `done_q` still tracks).
- `start`/`load_en` while `busy` are ignored.
- PC arithmetic is modulo 2^AW. Wrap cannot occur because of the clamp.

## Timing

- Reset (async assert, sync release) values:
  - State IDLE.
  - `pc`, `instr`, `result` = 0.
  - `instr_valid`, `busy`, `result_valid`, `finished`, `err_timeout`, `done_q` = 0.
- Memory contents are not reset. Reset mid-run aborts immediately with no `finished` pulse.
- Start at edge E0 → FETCH. `instr`/`instr_valid` are valid after E1.
- Done edge registered at edge Ek:
  - `instr_valid` drops after Ek.
  - The next instruction is valid after Ek+1 (2-cycle turnaround).
- Last instruction or result at Ek: END after Ek, `finished` high for cycle Ek..Ek+1, IDLE after Ek+1.
- Watchdog abort occurs `TIMEOUT` cycles after `instr_valid` rises.
- `prog_len` = 0: start at E0 → `finished` after E0, IDLE after E1.

## Test plan

- **Full program with result:** Load 7 words (32'h2401002d, 32'h2402ffec, 32'h2403ffc4, 32'h2404001e, 32'h00222821, 32'h00643021, 32'h00a62823), `prog_len`=7, and pulse `proc_done` 3 cycles after each `instr_valid`. Assert `disp_avail`=1 with `disp_value`=16'd5 on the 7th done. Required: `instr` sequence matches memory; `pc` 0..6; `result`=5; `result_valid`=1; one `finished` pulse; `err_timeout`=0.
- **Program end without result:** `prog_len`=3, `disp_avail`=0 throughout. Required: exactly 3 instructions issued; `finished` after the 3rd done; `result_valid`=0.
- **Level handling:** hold `proc_done` high for 10 cycles during ISSUE. Required: exactly one advance, `pc` 0→1.
- **Watchdog:** `TIMEOUT`=20, never assert done. Required: `err_timeout`=1 and `finished` 20 cycles after `instr_valid` rises. Also drive a done edge at exactly cycle 20: required `err_timeout`=0 and `pc` advances.
- **Boundaries:**
  - `prog_len`=0 → `finished` pulse, no `instr_valid`.
  - `prog_len`=12 with `DEPTH`=8 → 8 instructions issued.
  - `start`/`load_en` during busy → no effect; memory is unchanged when read back in the next run.
- **Reset mid-run:** drop `rst_n` while `pc`=4. Required: all outputs at reset values immediately. After release, a new start re-runs from `pc`=0 using the preserved memory.
